// File: rtl/posit_maxpool.sv
// Streaming 1-D max-pooling of posit samples over WINDOW-sample windows.
// Posits order like two's-complement integers; NaR in a window forces a NaR result.
module posit_maxpool #(
  parameter int POSIT_WIDTH = 16,
  parameter int WINDOW      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [POSIT_WIDTH-1:0] posit_i,
  input  logic                   valid_i,
  input  logic                   last_i,
  output logic                   ready_o,
  output logic [POSIT_WIDTH-1:0] posit_o,
  output logic                   valid_o,
  input  logic                   ready_i
);
  // Handshake: a word moves on a side only in a cycle where its valid and ready
  // are both high; valid/data are held stable by the sender until accepted.

  localparam int CW = $clog2(WINDOW);
  localparam logic [CW-1:0] CNT_LAST = CW'(WINDOW - 1);
  localparam logic [POSIT_WIDTH-1:0] NAR = {1'b1, {(POSIT_WIDTH-1){1'b0}}};

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [POSIT_WIDTH-1:0] max_q, max_d;
  logic                   nar_q, nar_d;
  logic [POSIT_WIDTH-1:0] posit_o_q, posit_o_d;
  logic                   valid_o_q, valid_o_d;

  logic                   closing_slot;
  logic                   out_space;
  logic                   accept;
  logic                   win_close;
  logic                   first;
  logic                   in_nar;
  logic [POSIT_WIDTH-1:0] merged_max;

  always_comb begin
    closing_slot = (cnt_q == CNT_LAST);
    out_space    = !valid_o_q || ready_i;
    // Accumulating samples never wait; only a window-closing sample needs output space.
    ready_o      = out_space || (!closing_slot && !(valid_i && last_i));
    accept       = valid_i && ready_o;
    win_close    = accept && (closing_slot || last_i);
    first        = (cnt_q == '0);
    in_nar       = (posit_i == NAR);
    if (first || ($signed(posit_i) > $signed(max_q))) merged_max = posit_i;
    else                                             merged_max = max_q;
  end

  always_comb begin
    cnt_d     = cnt_q;
    max_d     = max_q;
    nar_d     = nar_q;
    posit_o_d = posit_o_q;
    valid_o_d = valid_o_q;

    if (accept) begin
      max_d = merged_max;
      nar_d = (first ? 1'b0 : nar_q) | in_nar;
      if (win_close) cnt_d = '0;
      else           cnt_d = cnt_q + CW'(1);
    end

    if (win_close) begin
      // nar_q belongs to the previous window when this sample is the first one.
      posit_o_d = (in_nar || (nar_q && !first)) ? NAR : merged_max;
      valid_o_d = 1'b1;
    end else if (valid_o_q && ready_i) begin
      valid_o_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      max_q     <= '0;
      nar_q     <= 1'b0;
      posit_o_q <= '0;
      valid_o_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      nar_q     <= nar_d;
      posit_o_q <= posit_o_d;
      valid_o_q <= valid_o_d;
    end
  end

  assign posit_o = posit_o_q;
  assign valid_o = valid_o_q;

endmodule

// File: tb/tb_posit_maxpool.sv
// Bench for posit_maxpool: directed pooling scenarios plus randomized streaming,
// checked every cycle against a window-list model of the pooling rules.
module tb_posit_maxpool;
  localparam int W      = 16;
  localparam int WINDOW = 4;
  localparam logic [W-1:0] NAR = 16'h8000;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] posit_i;
  logic         valid_i;
  logic         last_i;
  logic         ready_o;
  logic [W-1:0] posit_o;
  logic         valid_o;
  logic         ready_i;

  int checks = 0;
  int errors = 0;
  bit rand_rdy = 1'b0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] win[$];

  posit_maxpool #(.POSIT_WIDTH(W), .WINDOW(WINDOW)) dut (
    .clk    (clk),
    .rst    (rst),
    .posit_i(posit_i),
    .valid_i(valid_i),
    .last_i (last_i),
    .ready_o(ready_o),
    .posit_o(posit_o),
    .valid_o(valid_o),
    .ready_i(ready_i)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: window maximum as plain arithmetic over the accepted samples.
  function automatic logic [W-1:0] win_result();
    logic [W-1:0] m;
    m = win[0];
    foreach (win[i]) begin
      if (win[i] == NAR) return NAR;
      if ($signed(win[i]) > $signed(m)) m = win[i];
    end
    return m;
  endfunction

  // scoreboard: outputs sampled on the falling edge, transactions applied for the next rising edge
  always @(negedge clk) begin
    logic exp_valid;
    logic exp_rdy;
    if (rst) begin
      chk("reset_valid_o", {31'b0, valid_o}, 32'd0);
      chk("reset_posit_o", {16'b0, posit_o}, 32'd0);
      chk("reset_ready_o", {31'b0, ready_o}, 32'd1);
      exp_q.delete();
      win.delete();
    end else begin
      exp_valid = (exp_q.size() != 0);
      chk("valid_o", {31'b0, valid_o}, {31'b0, exp_valid});
      if (exp_valid) chk("posit_o", {16'b0, posit_o}, {16'b0, exp_q[0]});
      exp_rdy = !(exp_valid && !ready_i &&
                  ((win.size() == WINDOW - 1) || (valid_i && last_i)));
      chk("ready_o", {31'b0, ready_o}, {31'b0, exp_rdy});
      if (valid_o && ready_i && exp_q.size() != 0) begin
        got_q.push_back(posit_o);
        void'(exp_q.pop_front());
      end
      if (valid_i && ready_o) begin
        win.push_back(posit_i);
        if (win.size() == WINDOW || last_i) begin
          exp_q.push_back(win_result());
          win.delete();
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) ready_i = ($urandom_range(0, 3) != 0);
  end

  // drivers: called and returning at rising edge + 1
  task automatic send(input logic [W-1:0] d, input logic l);
    bit done;
    done = 1'b0;
    valid_i = 1'b1;
    posit_i = d;
    last_i  = l;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (ready_o) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_got(input string name, input logic [W-1:0] v);
    if (got_q.size() == 0) chk({name, "_missing"}, 32'd0, 32'd1);
    else chk(name, {16'b0, got_q.pop_front()}, {16'b0, v});
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; last_i = 1'b0; posit_i = '0; ready_i = 1'b1;
    idle(3);
    chk("lit_reset_valid", {31'b0, valid_o}, 32'd0);
    rst = 1'b0;
    idle(1);

    // full window, single-cycle output
    send(16'h3000, 0); send(16'h5000, 0); send(16'h4000, 0); send(16'h0000, 0);
    chk("lit_t1_valid", {31'b0, valid_o}, 32'd1);
    chk("lit_t1_posit", {16'b0, posit_o}, 32'h5000);
    idle(1);
    chk("lit_t1_valid_drop", {31'b0, valid_o}, 32'd0);
    expect_got("lit_t1_out", 16'h5000);

    // NaR window then clean window
    send(16'hC000, 0); send(16'h0000, 0); send(16'h4000, 0); send(16'h8000, 0);
    send(16'h1000, 0); send(16'h2000, 0); send(16'h0800, 0); send(16'h0000, 0);
    idle(2);
    expect_got("lit_t2_nar", 16'h8000);
    expect_got("lit_t2_clean", 16'h2000);

    // backpressure: window 1 pending, window 2 closing sample stalls
    ready_i = 1'b0;
    send(16'h3000, 0); send(16'h5000, 0); send(16'h4000, 0); send(16'h0000, 0);
    send(16'h0100, 0); send(16'h0700, 0); send(16'h0300, 0);
    valid_i = 1'b1; posit_i = 16'h0200; last_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("lit_t3_stall", {31'b0, ready_o}, 32'd0);
      chk("lit_t3_hold", {16'b0, posit_o}, 32'h5000);
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    send(16'h0200, 0);
    send(16'h1111, 0); send(16'h2222, 0); send(16'h0001, 0); send(16'h0002, 0);
    idle(2);
    expect_got("lit_t3_w1", 16'h5000);
    expect_got("lit_t3_w2", 16'h0700);
    expect_got("lit_t3_w3", 16'h2222);

    // partial window via last_i, then a fresh full window
    send(16'h2000, 0); send(16'h3000, 1);
    send(16'h0A00, 0); send(16'h0B00, 0); send(16'h0C00, 0); send(16'h0900, 0);
    idle(2);
    expect_got("lit_t4_partial", 16'h3000);
    expect_got("lit_t4_full", 16'h0C00);

    // reset mid-window
    send(16'h7000, 0); send(16'h6000, 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    send(16'h0100, 0); send(16'h0200, 0); send(16'h0300, 0); send(16'h0400, 0);
    idle(2);
    expect_got("lit_t5_out", 16'h0400);
    chk("lit_t5_no_extra", got_q.size(), 32'd0);

    // randomized streaming with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] d;
      case ($urandom_range(0, 9))
        0:       d = NAR;
        1:       d = 16'h8000 | 16'($urandom_range(1, 16'h7FFF));
        2:       d = 16'h7FFF;
        default: d = 16'($urandom_range(0, 16'h7FFF));
      endcase
      send(d, ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    send(16'h0001, 1);
    rand_rdy = 1'b0;
    ready_i = 1'b1;
    idle(4);
    chk("drain_empty", exp_q.size(), 32'd0);
    chk("drain_valid", {31'b0, valid_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/posit_maxpool.md
# posit_maxpool

Streaming 1-D max-pooling stage placed directly after the posit ReLU in the activation path. It accepts one posit per cycle over a valid/ready handshake and tracks a running maximum over a window of `WINDOW` consecutive samples. At the end of each window it emits one posit holding the window maximum. Posit ordering equals two's-complement integer ordering, so no decoding is needed; NaR is handled explicitly.

## Interface
- `POSIT_WIDTH`, 16, posit word width in bits (≥ 3).
- `WINDOW`, 4, samples per pooling window (≥ 2).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `posit_i`  in  POSIT_WIDTH  input sample (typically ReLU output).
- `valid_i`  in  1  `posit_i` is valid.
- `last_i`  in  1  accepted sample closes the current window early (partial window).
- `ready_o`  out  1  block can accept a sample this cycle.
- `posit_o`  out  POSIT_WIDTH  window maximum.
- `valid_o`  out  1  `posit_o` is valid.
- `ready_i`  in  1  downstream accepts `posit_o` this cycle.

## Operation
- State:
  - sample counter `cnt`, width `$clog2(WINDOW)`, range 0..WINDOW-1;
  - running-max register `max_q`;
  - sticky NaR flag `nar_q`;
  - single-entry output register holding `posit_o` and `valid_o`.
- Input accept: `valid_i && ready_o`. Output accept: `valid_o && ready_i`.
- Comparison: signed compare of `POSIT_WIDTH`-bit words. A sample is NaR when its value is 1 followed by zeros (`{1'b1, {POSIT_WIDTH-1{1'b0}}}`).
- On an input accept with `cnt == 0`:
  - `max_q ← posit_i`;
  - `nar_q ← (posit_i is NaR)`.
- On an input accept with `cnt > 0`:
  - `max_q ← (posit_i > max_q signed) ? posit_i : max_q`;
  - `nar_q ← nar_q | (posit_i is NaR)`.
- Window close: an accept with `cnt == WINDOW-1` or with `last_i == 1`.
  - Output register loads NaR if `nar_q` or the incoming sample is NaR; otherwise it loads max(`max_q`, `posit_i`), using `posit_i` alone when `cnt == 0`.
  - `valid_o ← 1`; `cnt ← 0`.
- Non-closing accept: `cnt ← cnt + 1`.
- `ready_o = !valid_o || ready_i || !closing_slot`, where `closing_slot` means `cnt == WINDOW-1`.
  - Accumulation is never stalled. Only the final sample of a full window waits for output space.
  - When `last_i` forces a close and the output register is full and not being drained, that sample is also stalled: `ready_o` is low whenever `valid_i && last_i && valid_o && !ready_i`.
- Output register: cleared (`valid_o ← 0`) on an output accept unless it is reloaded in the same cycle. A simultaneous output accept and window close reloads it, keeping `valid_o` high.
- `posit_o` and `valid_o` hold stable while `valid_o && !ready_i`.
- `last_i` is ignored unless its sample is accepted.
- `last_i` on the `WINDOW`-th sample behaves exactly like a normal full close.

## Timing
- Reset values: `valid_o = 0`, `posit_o = 0`, `cnt = 0`, `max_q = 0`, `nar_q = 0`. `ready_o` is 1 out of reset.
- Reset asserted mid-window discards the partial window and any pending output. No output follows reset until a new window completes.
- Latency: `valid_o` rises on the clock edge that accepts the closing sample, i.e. the output is visible the cycle after that sample is presented.
- Throughput: one sample per cycle sustained when `ready_i` is held high. One output per `WINDOW` samples.
- `posit_o` is registered. The only combinational input-to-output paths are `ready_i`/`valid_i`/`last_i` to `ready_o`.

## Test plan
- WINDOW=4, POSIT_WIDTH=16, `ready_i=1`, back-to-back inputs 0x3000, 0x5000, 0x4000, 0x0000 -> one output 0x5000, `valid_o` high for exactly 1 cycle, the cycle after the 4th accept.
- Inputs 0xC000, 0x0000, 0x4000, 0x8000 (NaR in last slot) -> output 0x8000. Next window 0x1000, 0x2000, 0x0800, 0x0000 -> output 0x2000, confirming `nar_q` does not leak across windows.
- `ready_i=0` while window 1 (max 0x5000) is pending, then 8 further samples streamed -> samples 1..3 of window 2 accepted, 4th stalled (`ready_o=0`). `posit_o` holds 0x5000 stably. Raising `ready_i` -> 0x5000 then window 2 max delivered in order, no loss or duplication.
- Samples 0x2000, 0x3000 with `last_i` on the 2nd -> output 0x3000 after 2 samples. The following 4 samples form a fresh full window starting at `cnt = 0`.
- Assert `rst` for 1 cycle after 2 samples of a window, then 4 samples 0x0100, 0x0200, 0x0300, 0x0400 -> no output for the aborted window, then exactly one output 0x0400. All outputs read 0 during reset.
